// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall-bit indices, FSM encodings,
// exception cause codes and small helpers used by pipe_ctrl.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  typedef enum int {
    STALL_PC  = 0,
    STALL_IF  = 1,
    STALL_ID  = 2,
    STALL_EX  = 3,
    STALL_MEM = 4,
    STALL_WB  = 5
  } stall_bit_e;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic [31:0] {
    CAUSE_INTERRUPT    = 32'h0000_0001,
    CAUSE_SYSCALL      = 32'h0000_0008,
    CAUSE_INST_INVALID = 32'h0000_000a,
    CAUSE_OVERFLOW     = 32'h0000_000c,
    CAUSE_TRAP         = 32'h0000_000d,
    CAUSE_ERET         = 32'h0000_000e
  } exc_cause_e;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_ID   = 2'd1,
    REQ_EX   = 2'd2,
    REQ_MEM  = 2'd3
  } stall_src_e;

  // A stall from stage n freezes everything upstream; the stage after it takes a bubble.
  function automatic logic [STALL_W-1:0] stall_mask(input stall_src_e src);
    logic [STALL_W-1:0] m;
    case (src)
      REQ_MEM: m = 6'b011111;
      REQ_EX:  m = 6'b001111;
      REQ_ID:  m = 6'b000111;
      default: m = 6'b000000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] redirect_target(input logic [31:0] cause,
                                                  input logic [31:0] epc,
                                                  input logic [31:0] int_vec,
                                                  input logic [31:0] exc_vec);
    logic [31:0] tgt;
    if (cause == CAUSE_INTERRUPT)   tgt = int_vec;
    else if (cause == CAUSE_ERET)   tgt = epc;
    else                            tgt = exc_vec;
    return tgt;
  endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for stall-cycle performance debug.
// Clear wins over increment; the count sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o
);

  localparam logic [WIDTH-1:0] ONE = 1;

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                         cnt_d = '0;
    else if (inc_i && (cnt_q != '1))   cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests into a per-stage hold vector,
// sequences exception flush/redirect, and counts stalled cycles.
//
// state      | meaning
// RUN        | normal operation; stalls and exceptions honoured
// FLUSH      | flush pulse, new_pc valid for the fetch redirect
// RECOVER    | empty cycle while redirected fetch enters IF
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VEC = 32'h0000_0040,
  parameter logic [31:0] INT_VEC = 32'h0000_0020
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               stallreq_mem_i,
  input  logic [31:0]        excepttype_i,
  input  logic [31:0]        cp0_epc_i,
  input  logic               stall_cnt_clr_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic [31:0]        new_pc_o,
  output logic               busy_o,
  output logic [31:0]        stall_cnt_o
);

  logic [1:0]  state_q, state_d;
  logic        flush_q, flush_d;
  logic        busy_q, busy_d;
  logic [31:0] new_pc_q, new_pc_d;
  stall_src_e  stall_src;
  logic        in_run;
  logic        exc_take;

  assign in_run   = (state_q == ST_RUN);
  assign exc_take = in_run && (excepttype_i != ZeroWord);

  always_comb begin
    stall_src = REQ_NONE;
    if (stallreq_mem_i)      stall_src = REQ_MEM;
    else if (stallreq_ex_i)  stall_src = REQ_EX;
    else if (stallreq_id_i)  stall_src = REQ_ID;
  end

  // Held at zero while in reset so no stage register sees a stray hold.
  assign stall_o = (rst_n_i && in_run) ? stall_mask(stall_src) : '0;

  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN: begin
        if (exc_take) begin
          state_d  = ST_FLUSH;
          new_pc_d = redirect_target(excepttype_i, cp0_epc_i, INT_VEC, EXC_VEC);
        end
      end
      ST_FLUSH:   state_d = ST_RECOVER;
      ST_RECOVER: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  assign flush_d = (state_d == ST_FLUSH);
  assign busy_d  = (state_d != ST_RUN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_RUN;
      flush_q  <= 1'b0;
      busy_q   <= 1'b0;
      new_pc_q <= ZeroWord;
    end else begin
      state_q  <= state_d;
      flush_q  <= flush_d;
      busy_q   <= busy_d;
      new_pc_q <= new_pc_d;
    end
  end

  sat_counter #(
    .WIDTH (32)
  ) u_cnt (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (stall_o[STALL_PC]),
    .clr_i   (stall_cnt_clr_i),
    .cnt_o   (stall_cnt_o)
  );

  assign flush_o  = flush_q;
  assign busy_o   = busy_q;
  assign new_pc_o = new_pc_q;

endmodule
